write_buffer: RTL

- Posted write-back buffer between the cache controller and the 32x8 synchronous RAM.
- Accepts evicted dirty lines from the cache, queues them, and drains them to RAM when the RAM port is idle.
- Serves cache miss reads, either forwarded from the queue or read from RAM.
- Exposes occupancy and state for the board LEDs and seven-segment displays.

---
 rtl/write_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - posted write-back queue draining to a 32x8 sync RAM, with read forwarding
// Optional WB_COALESCE_EN: a push to an already-queued address overwrites that entry in place.
module write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   wb_ready,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_data,
  output logic                   ram_wren,
  input  logic [DATA_W-1:0]      ram_q,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [1:0]             state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t cur, nxt;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     cnt;

  logic              push, push_alloc, pop;
  logic              co_hit;
  logic [PW-1:0]     co_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic [ADDR_W-1:0] n_ram_addr;
  logic [DATA_W-1:0] n_ram_data;
  logic              n_ram_wren;
  logic              n_rd_valid;
  logic [DATA_W-1:0] n_rd_data;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign state    = cur;
  assign rd_ready = (cur == IDLE);

  // Reads win over drains, so a pop only happens in IDLE with no request pending.
  assign pop        = (cur == IDLE) && !rd_req && !empty;
  assign push       = wb_valid && wb_ready;
  assign push_alloc = push && !co_hit;

`ifdef WB_COALESCE_EN
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < cnt && q_addr[head + PW'(k)] == wb_addr && !(pop && k == 0)) begin
        co_hit = 1'b1;
        co_idx = head + PW'(k);
      end
    end
  end
  assign wb_ready = !full || co_hit;
`else
  assign co_hit   = 1'b0;
  assign co_idx   = '0;
  assign wb_ready = !full;
`endif

  // Scan oldest to youngest so the last match wins; a same-cycle push is younger still.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < cnt && q_addr[head + PW'(k)] == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[head + PW'(k)];
      end
    end
    if (push && wb_addr == rd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (push_alloc) begin
      q_addr[tail] <= wb_addr;
      q_data[tail] <= wb_data;
    end else if (push && co_hit) begin
      q_data[co_idx] <= wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_alloc) tail <= tail + 1'b1;
      if (pop)        head <= head + 1'b1;
      cnt <= cnt + CW'(push_alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      cur      <= nxt;
      ram_addr <= n_ram_addr;
      ram_data <= n_ram_data;
      ram_wren <= n_ram_wren;
      rd_valid <= n_rd_valid;
      rd_data  <= n_rd_data;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (rd_req)      nxt = fwd_hit ? IDLE : RD_ADDR;
        else if (!empty) nxt = WR;
      end
      WR:      nxt = IDLE;
      RD_ADDR: nxt = RD_DATA;
      RD_DATA: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    n_ram_addr = ram_addr;
    n_ram_data = ram_data;
    n_ram_wren = 1'b0;
    n_rd_valid = 1'b0;
    n_rd_data  = rd_data;
    case (cur)
      IDLE: begin
        if (rd_req) begin
          if (fwd_hit) begin
            n_rd_valid = 1'b1;
            n_rd_data  = fwd_data;
          end else begin
            n_ram_addr = rd_addr;
          end
        end else if (!empty) begin
          n_ram_addr = q_addr[head];
          n_ram_data = q_data[head];
          n_ram_wren = 1'b1;
        end
      end
      RD_DATA: begin
        n_rd_valid = 1'b1;
        n_rd_data  = ram_q;
      end
      default: ;
    endcase
  end

endmodule
